chunked_serial_adder: RTL and testbench
=======================================

Name: chunked_serial_adder

Overview:
Parametrised multi-cycle adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per clock, holding the carry in a register between chunks. Operands enter and results leave through valid/ready handshakes. It generalises the 4-bit ripple adder to arbitrary width, adds a subtract mode and status flags, and trades latency for adder area in ALU/accumulator datapaths.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits added per clock; 1 <= CHUNK <= WIDTH
NCHUNK, WIDTH/CHUNK, derived localparam, not overridable; chunk counter is max(1,clog2(NCHUNK)) bits

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
A  in  WIDTH  operand A
B  in  WIDTH  operand B
Cin  in  1  carry-in, used in add mode only
sub  in  1  0: A+B+Cin; 1: A-B, computed as A+~B+1 (Cin ignored)
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
S  out  WIDTH  sum/difference
Cout  out  1  carry out of MSB; in sub mode 1 = no borrow (A>=B unsigned)
ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB
zero  out  1  S == 0

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, res_valid=0, S=0, Cout=0, ovf=0, zero=0, carry/counter/operand registers cleared.
- States are IDLE, RUN and DONE. in_ready = (state==IDLE), combinational from the state register. res_valid = (state==DONE).
- IDLE: on an edge with in_valid && in_ready, capture A, B (B inverted if sub), the initial carry (sub ? 1 : Cin) and counter=0, then go to RUN. No capture while not in IDLE; in_valid is ignored outside IDLE.
- RUN: each edge adds chunk[counter] of the captured operands plus the carry register. It stores the chunk sum into an internal result register, updates the carry and increments the counter. At the edge where counter==NCHUNK-1, it also loads S, Cout, ovf and zero from the final values and goes to DONE.
- Latency: res_valid rises exactly NCHUNK edges after the accepting edge. For NCHUNK=1, that is the edge after acceptance.
- DONE: S, Cout, ovf and zero are held stable while res_valid=1. On an edge with res_ready=1, go to IDLE. in_ready is 1 in the following cycle. There is no IDLE bypass, so the minimum op period is NCHUNK+2 cycles.
- Output registers S, Cout, ovf and zero change only on entry to DONE. They keep the last result through IDLE and RUN.
- Carry ripples across chunk boundaries through the carry register only. The result is bit-identical to a full WIDTH-bit add for all inputs.
- Reset asserted in any state, including mid-RUN: the operation is aborted immediately and all outputs take their reset values. No partial result is ever presented.
- res_ready while not in DONE: ignored.
- Operand inputs A, B, Cin and sub are sampled only at the accepting edge. Later changes have no effect on the operation in flight.

Test Plan:
- WIDTH=16, CHUNK=4, add 0x1234+0x0FFF, Cin=0 -> S=0x2233, Cout=0, ovf=0, zero=0; res_valid high exactly 4 edges after acceptance, in_ready=0 throughout.
- Add 0xFFFF+0x0001, Cin=0 -> S=0x0000, Cout=1, zero=1, ovf=0 (carry crosses all chunks). Then 0x7FFF+0x0001 -> S=0x8000, ovf=1, Cout=0.
- sub=1, Cin=1 (ignored): 0x0005-0x0007 -> S=0xFFFE, Cout=0, ovf=0. Then 0x8000-0x0001 -> S=0x7FFF, Cout=1, ovf=1.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid and drive in_valid=1 with new operands. Required: res_valid and S stay stable and the new operands are not accepted. Raise res_ready, and the next op is accepted on the edge after in_ready returns to 1. Its result is correct.
- Mid-operation reset: assert reset_n=0 after 2 RUN edges. Required: res_valid=0, S=0 and the flags=0 immediately, without waiting for a clock; in_ready=1 once released. The next op, 0x00FF+0x0001, gives S=0x0100.
- Parameter sweep {WIDTH,CHUNK} = {4,4}, {8,1}, {32,8}, each with 200 random ops in both modes. Required: results match a reference WIDTH-bit add, and latency equals NCHUNK edges.

Source files
------------

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that ripples CHUNK bits per clock
// through a registered carry, with valid/ready handshakes on both sides.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] acc_next;
    logic             last_chunk;
    logic             msb_carry_in;

    always_comb begin
        a_chunk   = a_reg[int'(cnt_reg) * CHUNK +: CHUNK];
        b_chunk   = b_reg[int'(cnt_reg) * CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
        acc_next  = acc_reg;
        acc_next[int'(cnt_reg) * CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        // The MSB sum bit is a^b^cin, so the carry into it falls out of the chunk sum.
        msb_carry_in = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
        last_chunk   = (cnt_reg == CW'(NCHUNK - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            S         <= '0;
            Cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= A;
                        b_reg     <= sub ? ~B : B;
                        carry_reg <= sub ? 1'b1 : Cin;
                        cnt_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_reg   <= acc_next;
                    carry_reg <= chunk_sum[CHUNK];
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_chunk) begin
                        S         <= acc_next;
                        Cout      <= chunk_sum[CHUNK];
                        ovf       <= msb_carry_in ^ chunk_sum[CHUNK];
                        zero      <= (acc_next == '0);
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign res_valid = (state_reg == ST_DONE);
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: directed cases on a 16/4 instance plus a
// randomized sweep over three other WIDTH/CHUNK configurations.
`timescale 1ns/1ps
module tb_chunked_serial_adder;
    int checks   = 0;
    int failures = 0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic        Cin = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        in_ready, res_valid, Cout, ovf, zero;
    logic [15:0] S;

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub), .res_valid(res_valid),
        .res_ready(res_ready), .S(S), .Cout(Cout), .ovf(ovf), .zero(zero)
    );

    function automatic int sw_width(int i);
        case (i)
            0:       return 4;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int sw_chunk(int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    logic        sw_in_valid [3];
    logic        sw_res_ready[3];
    logic        sw_cin      [3];
    logic        sw_sub      [3];
    logic [31:0] sw_a        [3];
    logic [31:0] sw_b        [3];
    logic        sw_in_ready [3];
    logic        sw_res_valid[3];
    logic        sw_cout     [3];
    logic        sw_ovf      [3];
    logic        sw_zero     [3];
    logic [31:0] sw_s        [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
            localparam int W = sw_width(gi);
            localparam int C = sw_chunk(gi);
            logic [W-1:0] s_loc;
            chunked_serial_adder #(.WIDTH(W), .CHUNK(C)) u_sw (
                .clk(clk), .reset_n(reset_n),
                .in_valid(sw_in_valid[gi]), .in_ready(sw_in_ready[gi]),
                .A(sw_a[gi][W-1:0]), .B(sw_b[gi][W-1:0]),
                .Cin(sw_cin[gi]), .sub(sw_sub[gi]),
                .res_valid(sw_res_valid[gi]), .res_ready(sw_res_ready[gi]),
                .S(s_loc), .Cout(sw_cout[gi]), .ovf(sw_ovf[gi]), .zero(sw_zero[gi])
            );
            assign sw_s[gi] = 32'(s_loc);
        end
    endgenerate

    // Reference: plain integer arithmetic on w-bit values; overflow judged by
    // whether the true signed sum leaves the w-bit two's complement range.
    function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                  input bit cin, input bit is_sub,
                                  output longint unsigned s, output bit co, output bit ov, output bit z);
        longint unsigned mask, bop, full;
        longint          sa, sbv, ssum, smax;
        int              c;
        mask = (64'd1 << w) - 1;
        a    = a & mask;
        bop  = is_sub ? (~b & mask) : (b & mask);
        c    = is_sub ? 1 : int'(cin);
        full = a + bop + longint'(c);
        s    = full & mask;
        co   = ((full >> w) & 1) != 0;
        smax = (64'sd1 <<< (w - 1)) - 1;
        sa   = longint'(a);
        sbv  = longint'(bop);
        if (sa > smax)  sa  = sa  - (64'sd1 <<< w);
        if (sbv > smax) sbv = sbv - (64'sd1 <<< w);
        ssum = sa + sbv + longint'(c);
        ov   = (ssum > smax) || (ssum < -(smax + 1));
        z    = (s == 0);
    endfunction

    // Present one operation to the 16/4 instance and wait for its result.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic is_sub, output int lat, output bit ir_seen);
        A = a; B = b; Cin = cin; sub = is_sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
        lat = 0; ir_seen = 1'b0;
        while (!res_valid && lat < 64) begin
            if (in_ready) ir_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, res_valid, S, Cout, ovf, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            failures++;
            $display("FAIL reset_state got rdy=%b vld=%b S=%h C=%b V=%b Z=%b want rdy=1 vld=0 S=0000 flags=0",
                     in_ready, res_valid, S, Cout, ovf, zero);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, res_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, res_valid);
        end
        $display("reset: rdy=%b vld=%b S=%h", in_ready, res_valid, S);
    endtask

    task automatic test_directed();
        logic [15:0] ta [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0000};
        logic [15:0] tb [6] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000};
        logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [18:0] te [6] = '{{16'h2233, 3'b000}, {16'h0000, 3'b101}, {16'h8000, 3'b010},
                                {16'hFFFE, 3'b000}, {16'h7FFF, 3'b110}, {16'h0000, 3'b101}};
        int lat;
        bit ir_seen;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], tc[i], ts[i], lat, ir_seen);
            checks++;
            if ({S, Cout, ovf, zero} !== te[i]) begin
                failures++;
                $display("FAIL directed_%0d got S=%h C=%b V=%b Z=%b want S=%h C=%b V=%b Z=%b",
                         i, S, Cout, ovf, zero, te[i][18:3], te[i][2], te[i][1], te[i][0]);
            end
            checks++;
            if (lat !== 4 || ir_seen !== 1'b0) begin
                failures++;
                $display("FAIL directed_lat_%0d got lat=%0d rdy_seen=%b want lat=4 rdy_seen=0", i, lat, ir_seen);
            end
            $display("op %h %s %h cin=%b -> S=%h C=%b V=%b Z=%b lat=%0d",
                     ta[i], ts[i] ? "-" : "+", tb[i], tc[i], S, Cout, ovf, zero, lat);
            release_result();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ir_seen;
        run_op(16'h4321, 16'h1111, 1'b0, 1'b0, lat, ir_seen);
        A = 16'h0F0F; B = 16'h0101; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({res_valid, in_ready, S} !== {1'b1, 1'b0, 16'h5432}) begin
                failures++;
                $display("FAIL backpressure_hold_%0d got vld=%b rdy=%b S=%h want vld=1 rdy=0 S=5432",
                         i, res_valid, in_ready, S);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if ({in_ready, res_valid, S} !== {1'b1, 1'b0, 16'h5432}) begin
            failures++;
            $display("FAIL backpressure_release got rdy=%b vld=%b S=%h want rdy=1 vld=0 S=5432",
                     in_ready, res_valid, S);
        end
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, lat, ir_seen);
        checks++;
        if ({S, Cout, ovf, zero, lat} !== {16'h1010, 3'b000, 32'd4}) begin
            failures++;
            $display("FAIL backpressure_next got S=%h C=%b V=%b Z=%b lat=%0d want S=1010 flags=0 lat=4",
                     S, Cout, ovf, zero, lat);
        end
        $display("op 0f0f + 0101 after backpressure -> S=%h lat=%0d", S, lat);
        release_result();
    endtask

    task automatic test_mid_reset();
        int lat;
        bit ir_seen;
        A = 16'hFFFF; B = 16'h0001; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, S, Cout, ovf, zero} !== {1'b0, 16'h0, 3'b000}) begin
            failures++;
            $display("FAIL mid_reset got vld=%b S=%h C=%b V=%b Z=%b want vld=0 S=0000 flags=0",
                     res_valid, S, Cout, ovf, zero);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, res_valid} !== 2'b10) begin
            failures++;
            $display("FAIL mid_reset_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, res_valid);
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, ir_seen);
        checks++;
        if ({S, Cout, ovf, zero, lat} !== {16'h0100, 3'b000, 32'd4}) begin
            failures++;
            $display("FAIL mid_reset_next got S=%h C=%b V=%b Z=%b lat=%0d want S=0100 flags=0 lat=4",
                     S, Cout, ovf, zero, lat);
        end
        $display("op 00ff + 0001 after reset -> S=%h lat=%0d", S, lat);
        release_result();
    endtask

    task automatic test_random();
        longint unsigned es;
        bit              ec, ev, ez;
        logic [15:0]     a, b;
        logic            cin, is_sub;
        int              lat;
        bit              ir_seen;
        for (int n = 0; n < 100; n++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); is_sub = 1'($urandom);
            model(16, 64'(a), 64'(b), cin, is_sub, es, ec, ev, ez);
            run_op(a, b, cin, is_sub, lat, ir_seen);
            checks++;
            if ({S, Cout, ovf, zero} !== {es[15:0], ec, ev, ez} || lat != 4) begin
                failures++;
                $display("FAIL random_%0d got S=%h C=%b V=%b Z=%b lat=%0d want S=%h C=%b V=%b Z=%b lat=4",
                         n, S, Cout, ovf, zero, lat, es[15:0], ec, ev, ez);
            end
            $display("rnd %h %s %h cin=%b -> S=%h", a, is_sub ? "-" : "+", b, cin, S);
            release_result();
        end
    endtask

    task automatic test_sweep();
        longint unsigned es, mask;
        bit              ec, ev, ez;
        logic [31:0]     a, b;
        logic            cin, is_sub;
        int              w, nch, lat;
        for (int k = 0; k < 3; k++) begin
            w    = sw_width(k);
            nch  = w / sw_chunk(k);
            mask = (64'd1 << w) - 1;
            for (int n = 0; n < 200; n++) begin
                a = 32'(64'($urandom) & mask); b = 32'(64'($urandom) & mask);
                cin = 1'($urandom); is_sub = 1'(n & 1);
                model(w, 64'(a), 64'(b), cin, is_sub, es, ec, ev, ez);
                sw_a[k] = a; sw_b[k] = b; sw_cin[k] = cin; sw_sub[k] = is_sub; sw_in_valid[k] = 1'b1;
                @(posedge clk); #1;
                sw_in_valid[k] = 1'b0;
                sw_a[k] = $urandom; sw_b[k] = $urandom;
                lat = 0;
                while (!sw_res_valid[k] && lat < 64) begin
                    @(posedge clk); #1;
                    lat++;
                end
                checks++;
                if ({sw_s[k], sw_cout[k], sw_ovf[k], sw_zero[k]} !== {32'(es), ec, ev, ez} || lat != nch) begin
                    failures++;
                    $display("FAIL sweep_w%0d_%0d got S=%h C=%b V=%b Z=%b lat=%0d want S=%h C=%b V=%b Z=%b lat=%0d",
                             w, n, sw_s[k], sw_cout[k], sw_ovf[k], sw_zero[k], lat,
                             32'(es), ec, ev, ez, nch);
                end
                $display("sweep w=%0d %h %s %h -> S=%h lat=%0d", w, a, is_sub ? "-" : "+", b, sw_s[k], lat);
                sw_res_ready[k] = 1'b1;
                @(posedge clk); #1;
                sw_res_ready[k] = 1'b0;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            sw_in_valid[k] = 1'b0; sw_res_ready[k] = 1'b0; sw_cin[k] = 1'b0;
            sw_sub[k] = 1'b0; sw_a[k] = '0; sw_b[k] = '0;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
